// File: rtl/trig_conditioner.sv
// Turns two raw Arduino trigger pins into mutually exclusive MZ/Rabi triggers with hold and lockout timing.
// Pin-to-trigger latency DEBOUNCE+3 cycles; no backpressure: requests while busy are dropped and counted.
module trig_conditioner #(
  parameter int DEBOUNCE  = 16,
  parameter int MZ_HOLD   = 168300,
  parameter int MZ_GAP    = 1000,
  parameter int RABI_HOLD = 2,
  parameter int RABI_GAP  = 70000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mz_req_in,
  input  logic       rabi_req_in,
  output logic       mz_trig,
  output logic       rabi_trig,
  output logic       busy,
  output logic       done,
  output logic [7:0] drop_cnt
);

  localparam logic [31:0] DB_LIM  = (DEBOUNCE  < 1) ? 32'd1 : 32'(DEBOUNCE);
  localparam logic [31:0] MZ_H    = (MZ_HOLD   < 1) ? 32'd1 : 32'(MZ_HOLD);
  localparam logic [31:0] MZ_G    = (MZ_GAP    < 1) ? 32'd1 : 32'(MZ_GAP);
  localparam logic [31:0] RABI_H  = (RABI_HOLD < 1) ? 32'd1 : 32'(RABI_HOLD);
  localparam logic [31:0] RABI_G  = (RABI_GAP  < 1) ? 32'd1 : 32'(RABI_GAP);

  typedef enum logic [1:0] {IDLE, MZ_RUN, RABI_RUN, GAP} state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [1:0]  sync1;
  logic [1:0]  sync2;
  logic [1:0]  filt;
  logic [1:0]  filt_q;
  logic [31:0] db_cnt [2];
  logic [1:0]  req;
  logic        mz_req;
  logic        rabi_req;
  logic [1:0]  drop_inc;
  logic [8:0]  drop_sum;

  // Bit 0 is the MZ channel, bit 1 the Rabi channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      filt   <= '0;
      filt_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1  <= {rabi_req_in, mz_req_in};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LIM) begin
          filt[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign req      = filt & ~filt_q;
  assign mz_req   = req[0];
  assign rabi_req = req[1];

  // In IDLE only a Rabi request losing to a simultaneous MZ request is rejected.
  always_comb begin
    drop_inc = '0;
    if (state == IDLE) drop_inc = {1'b0, mz_req & rabi_req};
    else               drop_inc = {1'b0, mz_req} + {1'b0, rabi_req};
  end

  assign drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mz_trig   <= 1'b0;
      rabi_trig <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      done     <= 1'b0;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      case (state)
        IDLE: begin
          if (mz_req) begin
            state   <= MZ_RUN;
            cnt     <= MZ_H;
            mz_trig <= 1'b1;
            busy    <= 1'b1;
          end else if (rabi_req) begin
            state     <= RABI_RUN;
            cnt       <= RABI_H;
            rabi_trig <= 1'b1;
            busy      <= 1'b1;
          end
        end
        MZ_RUN: begin
          if (cnt == 32'd1) begin
            state   <= GAP;
            cnt     <= MZ_G;
            mz_trig <= 1'b0;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        RABI_RUN: begin
          if (cnt == 32'd1) begin
            state     <= GAP;
            cnt       <= RABI_G;
            rabi_trig <= 1'b0;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        GAP: begin
          if (cnt == 32'd1) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          mz_trig   <= 1'b0;
          rabi_trig <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  a_trig_excl: assert property (@(posedge clk) disable iff (!rst_n) !(mz_trig && rabi_trig));

endmodule
